// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between two CPU pipeline stages and the inter-stage buffer.
// master = stage environment (producer + consumer), slave = the buffer itself.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 128
);
  logic              flush;
  logic              up_valid;
  logic              up_ready;
  logic [DATA_W-1:0] up_data;
  logic              up_next_ds;
  logic              dn_valid;
  logic              dn_ready;
  logic [DATA_W-1:0] dn_data;
  logic              is_in_ds_o;

  modport master (
    output flush, up_valid, up_data, up_next_ds, dn_ready,
    input  up_ready, dn_valid, dn_data, is_in_ds_o
  );

  modport slave (
    input  flush, up_valid, up_data, up_next_ds, dn_ready,
    output up_ready, dn_valid, dn_data, is_in_ds_o
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register: 2-entry skid buffer with flush and NOP bubble output.
// Optional PIPE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_buf #(
  parameter int                DATA_W  = 128,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_buf_if.slave   bus,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state;
  logic              up_ready_q, dn_valid_q, in_ds_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept;

  assign accept = bus.up_valid & up_ready_q;

  // up_ready is a pure flop: it only drops in TWO, so dn_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state      <= EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
      in_ds_q    <= 1'b0;
    end else begin
      if (accept) in_ds_q <= bus.up_next_ds;
      case (state)
        EMPTY: if (accept) begin
          main_data  <= bus.up_data;
          dn_valid_q <= 1'b1;
          state      <= ONE;
        end
        ONE: if (bus.dn_ready) begin
          if (accept) main_data <= bus.up_data;
          else begin
            dn_valid_q <= 1'b0;
            state      <= EMPTY;
          end
        end else if (accept) begin
          skid_data  <= bus.up_data;
          up_ready_q <= 1'b0;
          state      <= TWO;
        end
        TWO: if (bus.dn_ready) begin
          main_data  <= skid_data;
          up_ready_q <= 1'b1;
          state      <= ONE;
        end
        default: begin
          state      <= EMPTY;
          up_ready_q <= 1'b1;
          dn_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.up_ready   = up_ready_q;
  assign bus.dn_valid   = dn_valid_q;
  assign bus.dn_data    = dn_valid_q ? main_data : NOP_VAL;
  assign bus.is_in_ds_o = in_ds_q;

`ifdef PIPE_PERF_EN
  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (dn_valid_q && !bus.dn_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (!dn_valid_q && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: reset, streaming, backpressure, flush, delay-slot flag, counters.
module tb_pipe_stage_buf;
  localparam int                DW  = 16;
  localparam int                CW  = 4;
  localparam logic [DW-1:0]     NOP = 16'hDEAD;

  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0] stall_cnt, bubble_cnt;
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] out_q[$];

  pipe_stage_buf_if #(.DATA_W(DW)) bus ();

  pipe_stage_buf #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // record every real downstream transfer
  always @(posedge clk)
    if (!rst && !bus.flush && bus.dn_valid && bus.dn_ready) out_q.push_back(bus.dn_data);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic [DW-1:0] exp[]);
    chk({tag, "_n"}, out_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < out_q.size(); i++)
      chk(tag, out_q[i], exp[i]);
    out_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.up_valid = 1'b1; bus.up_data = 16'h00A5;
    bus.up_next_ds = 1'b1; bus.dn_ready = 1'b1;
    tick(); tick();
    chk("rst_dn_valid", bus.dn_valid, 0);
    chk("rst_dn_data", bus.dn_data, NOP);
    chk("rst_up_ready", bus.up_ready, 1);
    chk("rst_in_ds", bus.is_in_ds_o, 0);
    rst = 1'b0; bus.up_valid = 1'b0; bus.up_next_ds = 1'b0;
    tick(); tick();
    chk("rst_no_emit", bus.dn_valid, 0);
    chk_out("rst_out", '{});

    // streaming
    push(16'h1); chk("s1", bus.dn_data, 16'h1);
    push(16'h2); chk("s2", bus.dn_data, 16'h2);
    push(16'h3); chk("s3", bus.dn_data, 16'h3);
    bus.up_valid = 1'b0; tick();
    chk("s_end_valid", bus.dn_valid, 0);
    chk("s_end_nop", bus.dn_data, NOP);
    chk_out("s_out", '{16'h1, 16'h2, 16'h3});

    // backpressure
    bus.dn_ready = 1'b0;
    push(16'h10); chk("bp_rdy1", bus.up_ready, 1);
    push(16'h11); chk("bp_rdy2", bus.up_ready, 0);
    chk("bp_head", bus.dn_data, 16'h10);
    push(16'h12); chk("bp_hold_rdy", bus.up_ready, 0);
    chk("bp_hold_head", bus.dn_data, 16'h10);
    bus.dn_ready = 1'b1;
    tick(); chk("bp_o11", bus.dn_data, 16'h11);
    chk("bp_rdy_back", bus.up_ready, 1);
    tick(); chk("bp_o12", bus.dn_data, 16'h12);
    bus.up_valid = 1'b0; tick();
    chk("bp_empty", bus.dn_valid, 0);
    chk_out("bp_out", '{16'h10, 16'h11, 16'h12});

    // flush in TWO
    bus.dn_ready = 1'b0;
    push(16'h20); push(16'h21);
    chk("fl_two", bus.up_ready, 0);
    bus.flush = 1'b1; bus.up_data = 16'h22; bus.dn_ready = 1'b1;
    tick();
    chk("fl_valid", bus.dn_valid, 0);
    chk("fl_rdy", bus.up_ready, 1);
    chk("fl_nop", bus.dn_data, NOP);
    bus.flush = 1'b0; bus.up_valid = 1'b0;
    tick(); tick();
    chk("fl_after", bus.dn_valid, 0);
    chk_out("fl_out", '{});

    // delay-slot flag
    bus.up_next_ds = 1'b1; push(16'h40);
    chk("ds_set", bus.is_in_ds_o, 1);
    bus.up_valid = 1'b0; bus.up_next_ds = 1'b0; tick();
    chk("ds_hold", bus.is_in_ds_o, 1);
    bus.flush = 1'b1; tick();
    chk("ds_flush", bus.is_in_ds_o, 0);
    bus.flush = 1'b0; bus.up_next_ds = 1'b1; tick();
    chk("ds_no_accept", bus.is_in_ds_o, 0);
    bus.up_next_ds = 1'b0;
    out_q.delete();

    // counters
    rst = 1'b1; tick(); rst = 1'b0;
    bus.dn_ready = 1'b0;
    push(16'h30);
    bus.up_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("held_valid", bus.dn_valid, 1);
`ifdef PIPE_PERF_EN
    chk("stall_sat", stall_cnt, 4'hF);
    chk("bubble_1", bubble_cnt, 4'h1);
`else
    chk("stall_off", stall_cnt, 0);
    chk("bubble_off", bubble_cnt, 0);
`endif
    bus.dn_ready = 1'b1; tick(); tick();
`ifdef PIPE_PERF_EN
    chk("stall_keep", stall_cnt, 4'hF);
    chk("bubble_2", bubble_cnt, 4'h2);
`else
    chk("bubble_off2", bubble_cnt, 0);
`endif
    chk_out("cnt_out", '{16'h30});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
